mult_pack_fifo: RTL and testbench

Downstream consumer of the 4-bit `multiply` result stream in the synchronizer/divider datapath. It samples one nibble per divider enable pulse on `fast_clk` and packs consecutive nibble pairs into bytes, low nibble first. Completed bytes go into a small FIFO, which the next stage drains through a valid/ready handshake. Overflow is recorded as a sticky status flag.

---
 rtl/mult_pack_fifo_if.sv | 46 ++++
 rtl/mult_pack_fifo.sv | 112 +++++++++++
 tb/tb_mult_pack_fifo.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_pack_fifo_if.sv
// -----------------------------------------------------------------------------
// mult_pack_fifo_if
// Bundles the nibble input stream, the byte output handshake and the status
// outputs of mult_pack_fifo. The clock and reset stay plain module ports.
//
// Handshake: out_valid is high whenever the FIFO holds a byte; a byte is
// consumed on a rising edge where out_valid && out_ready are both high.
// out_ready while out_valid is low has no effect.
//
// Signals:
//   en         sample strobe (one cycle wide)
//   multiply   4-bit nibble, valid when en=1
//   out_ready  consumer accepts the head byte this cycle
//   out_valid  FIFO non-empty
//   out_byte   head byte, 8'h00 when empty
//   out_parity stored even parity of head entry (0 when empty / not built)
//   count      number of stored entries
//   overflow   sticky: a completed byte was dropped
//   fsm_hi     debug view of the assembly FSM (1 = waiting for high nibble)
// Modports: master (stimulus / upstream+downstream side), slave (the FIFO).
// -----------------------------------------------------------------------------
interface mult_pack_fifo_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          en;
   logic [3:0]    multiply;
   logic          out_ready;
   logic          out_valid;
   logic [7:0]    out_byte;
   logic          out_parity;
   logic [CW-1:0] count;
   logic          overflow;
   logic          fsm_hi;

   modport master (
      output en, multiply, out_ready,
      input  out_valid, out_byte, out_parity, count, overflow, fsm_hi
   );

   modport slave (
      input  en, multiply, out_ready,
      output out_valid, out_byte, out_parity, count, overflow, fsm_hi
   );
endinterface

// File: rtl/mult_pack_fifo.sv
// -----------------------------------------------------------------------------
// mult_pack_fifo
// Samples one 4-bit multiply nibble per en pulse, packs nibble pairs into bytes
// (low nibble first) and stores completed bytes in a DEPTH-entry FIFO drained
// through a valid/ready handshake. A byte completed while the FIFO is full and
// not being popped is dropped and sets the sticky overflow flag.
//
// Ports:
//   fast_clk  sole clock, rising edge
//   rst       synchronous active-high reset
//   bus       mult_pack_fifo_if.slave (en, multiply, out_ready in;
//             out_valid, out_byte, out_parity, count, overflow, fsm_hi out)
//
// Configuration macro: MULT_PACK_PARITY_EN
//   defined   -> 9-bit entries holding byte plus even parity; out_parity
//                shows the head entry's stored parity
//   undefined -> 8-bit entries, out_parity tied to 0
// -----------------------------------------------------------------------------
module mult_pack_fifo #(
   parameter int DEPTH = 4
) (
   input  logic           fast_clk,
   input  logic           rst,
   mult_pack_fifo_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
`ifdef MULT_PACK_PARITY_EN
   localparam int EW = 9;
`else
   localparam int EW = 8;
`endif

   typedef enum logic {LO = 1'b0, HI = 1'b1} state_t;

   state_t        state;
   logic [3:0]    lo_nib;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic [EW-1:0] mem [DEPTH];

   logic [7:0]    push_byte;
   logic [EW-1:0] push_entry;
   logic [EW-1:0] head;
   logic          push_req;
   logic          push_ok;
   logic          pop;
   logic          empty;
   logic          full;

   always_comb begin
      push_byte  = {bus.multiply, lo_nib};
      push_req   = bus.en && (state == HI);
      empty      = (count == '0);
      full       = (count == CW'(DEPTH));
      pop        = !empty && bus.out_ready;
      // A pop in the same cycle frees the slot, so a push at full is kept.
      push_ok    = push_req && (!full || pop);
`ifdef MULT_PACK_PARITY_EN
      push_entry = {^push_byte, push_byte};
`else
      push_entry = push_byte;
`endif
   end

   // Assembly FSM, pointers, occupancy and sticky overflow.
   always_ff @(posedge fast_clk) begin
      if (rst) begin
         state    <= LO;
         lo_nib   <= 4'h0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (bus.en) begin
            case (state)
               LO: begin
                  lo_nib <= bus.multiply;
                  state  <= HI;
               end
               HI: state <= LO;
               default: state <= LO;
            endcase
         end
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         if (push_ok && !pop)      count <= count + CW'(1);
         else if (pop && !push_ok) count <= count - CW'(1);
         if (push_req && !push_ok) overflow <= 1'b1;
      end
   end

   // Storage needs no reset: entries are only visible while count covers them.
   always_ff @(posedge fast_clk) begin
      if (!rst && push_ok) mem[wr_ptr] <= push_entry;
   end

   assign head          = mem[rd_ptr];
   assign bus.out_valid = !empty;
   assign bus.out_byte  = empty ? 8'h00 : head[7:0];
`ifdef MULT_PACK_PARITY_EN
   assign bus.out_parity = empty ? 1'b0 : head[8];
`else
   assign bus.out_parity = 1'b0;
`endif
   assign bus.count     = count;
   assign bus.overflow  = overflow;
   assign bus.fsm_hi    = (state == HI);
endmodule

// File: tb/tb_mult_pack_fifo.sv
// -----------------------------------------------------------------------------
// tb_mult_pack_fifo
// Drives nibble pairs into mult_pack_fifo and checks every popped byte against
// an expected queue, plus occupancy, overflow and FSM phase after each cycle.
// -----------------------------------------------------------------------------
module tb_mult_pack_fifo;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic fast_clk;
   logic rst;

   mult_pack_fifo_if #(.DEPTH(DEPTH)) bus ();

   mult_pack_fifo #(.DEPTH(DEPTH)) dut (
      .fast_clk (fast_clk),
      .rst      (rst),
      .bus      (bus.slave)
   );

   // clock / reset
   initial fast_clk = 1'b0;
   always #5 fast_clk = ~fast_clk;

   // scoreboard
   logic [7:0] exp_q[$];
   logic       exp_ovf;
   logic       model_hi;
   logic [3:0] model_lo;
   int         pass_cnt;
   int         total_cnt;

   function automatic logic par(input logic [7:0] b);
`ifdef MULT_PACK_PARITY_EN
      return ^b;
`else
      return 1'b0;
`endif
   endfunction

   task automatic clear_model();
      exp_q.delete();
      exp_ovf  = 1'b0;
      model_hi = 1'b0;
      model_lo = 4'h0;
   endtask

   // reset for one cycle; e/m let en be asserted alongside rst
   task automatic do_reset(input logic e, input logic [3:0] m);
      rst = 1'b1;
      bus.en = e;
      bus.multiply = m;
      @(posedge fast_clk);
      #1;
      rst = 1'b0;
      bus.en = 1'b0;
      bus.multiply = 4'h0;
      clear_model();
   endtask

   // one clock cycle of stimulus with scoreboard bookkeeping
   task automatic cycle(input logic e, input logic [3:0] m);
      logic [7:0]    b;
      logic [CW-1:0] exp_cnt;
      bus.en = e;
      bus.multiply = m;
      if (bus.out_ready && exp_q.size() > 0) begin
         b = exp_q.pop_front();
         total_cnt++;
         if (bus.out_valid !== 1'b1 || bus.out_byte !== b || bus.out_parity !== par(b))
            $display("FAIL pop_head: got v=%b byte=%h par=%b expected v=1 byte=%h par=%b",
                     bus.out_valid, bus.out_byte, bus.out_parity, b, par(b));
         else pass_cnt++;
      end
      if (e) begin
         if (model_hi) begin
            b = {m, model_lo};
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else exp_ovf = 1'b1;
            model_hi = 1'b0;
         end else begin
            model_lo = m;
            model_hi = 1'b1;
         end
      end
      @(posedge fast_clk);
      #1;
      bus.en = 1'b0;
      bus.multiply = 4'h0;
      exp_cnt = CW'(exp_q.size());
      total_cnt++;
      if (bus.count !== exp_cnt || bus.overflow !== exp_ovf || bus.fsm_hi !== model_hi)
         $display("FAIL state: got count=%0d ovf=%b hi=%b expected count=%0d ovf=%b hi=%b",
                  bus.count, bus.overflow, bus.fsm_hi, exp_cnt, exp_ovf, model_hi);
      else pass_cnt++;
   endtask

   // driver: 3 idle cycles, low nibble, 3 idle cycles, high nibble.
   // rdy_hi is the out_ready value during the high-nibble cycle.
   task automatic send_byte(input logic [7:0] b, input logic rdy_hi);
      logic rdy_save;
      repeat (3) cycle(1'b0, 4'h0);
      cycle(1'b1, b[3:0]);
      repeat (3) cycle(1'b0, 4'h0);
      rdy_save = bus.out_ready;
      bus.out_ready = rdy_hi;
      cycle(1'b1, b[7:4]);
      bus.out_ready = rdy_save;
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      repeat (DEPTH + 2) cycle(1'b0, 4'h0);
      bus.out_ready = 1'b0;
      total_cnt++;
      if (bus.out_valid !== 1'b0 || bus.out_byte !== 8'h00 || bus.out_parity !== 1'b0)
         $display("FAIL drained_empty: got v=%b byte=%h par=%b expected v=0 byte=00 par=0",
                  bus.out_valid, bus.out_byte, bus.out_parity);
      else pass_cnt++;
   endtask

   // tests
   task automatic test_reset();
      bus.out_ready = 1'b0;
      do_reset(1'b0, 4'h0);
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", bus.out_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_byte !== 8'h00) $display("FAIL rst_byte: got %h expected 00", bus.out_byte);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_parity !== 1'b0) $display("FAIL rst_parity: got %b expected 0", bus.out_parity);
      else pass_cnt++;
      total_cnt++;
      if (bus.count !== '0) $display("FAIL rst_count: got %0d expected 0", bus.count);
      else pass_cnt++;
      total_cnt++;
      if (bus.overflow !== 1'b0) $display("FAIL rst_overflow: got %b expected 0", bus.overflow);
      else pass_cnt++;
      total_cnt++;
      if (bus.fsm_hi !== 1'b0) $display("FAIL rst_fsm: got %b expected 0", bus.fsm_hi);
      else pass_cnt++;
   endtask

   task automatic test_single();
      do_reset(1'b0, 4'h0);
      send_byte(8'hA3, 1'b0);
      total_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'hA3 || bus.count !== CW'(1) || bus.overflow !== 1'b0)
         $display("FAIL single_byte: got v=%b byte=%h count=%0d ovf=%b expected v=1 byte=a3 count=1 ovf=0",
                  bus.out_valid, bus.out_byte, bus.count, bus.overflow);
      else pass_cnt++;
      drain();
   endtask

   task automatic test_overflow();
      do_reset(1'b0, 4'h0);
      for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 1'b0);
      total_cnt++;
      if (bus.count !== CW'(4) || bus.overflow !== 1'b1)
         $display("FAIL overflow_full: got count=%0d ovf=%b expected count=4 ovf=1", bus.count, bus.overflow);
      else pass_cnt++;
      drain();
      total_cnt++;
      if (bus.overflow !== 1'b1)
         $display("FAIL overflow_sticky: got %b expected 1", bus.overflow);
      else pass_cnt++;
   endtask

   task automatic test_full_pop();
      do_reset(1'b0, 4'h0);
      for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i), 1'b0);
      send_byte(8'h24, 1'b1);
      total_cnt++;
      if (bus.count !== CW'(4) || bus.overflow !== 1'b0 || bus.out_byte !== 8'h21)
         $display("FAIL full_push_pop: got count=%0d ovf=%b head=%h expected count=4 ovf=0 head=21",
                  bus.count, bus.overflow, bus.out_byte);
      else pass_cnt++;
      drain();
   endtask

   task automatic test_reset_partial();
      do_reset(1'b0, 4'h0);
      repeat (3) cycle(1'b0, 4'h0);
      cycle(1'b1, 4'h5);
      repeat (3) cycle(1'b0, 4'h0);
      // reset coincides with the would-be high nibble; reset wins
      do_reset(1'b1, 4'h7);
      total_cnt++;
      if (bus.fsm_hi !== 1'b0 || bus.count !== '0 || bus.out_valid !== 1'b0)
         $display("FAIL rst_mid: got hi=%b count=%0d v=%b expected hi=0 count=0 v=0",
                  bus.fsm_hi, bus.count, bus.out_valid);
      else pass_cnt++;
      send_byte(8'h21, 1'b0);
      total_cnt++;
      if (bus.out_byte !== 8'h21 || bus.count !== CW'(1))
         $display("FAIL rst_partial_byte: got byte=%h count=%0d expected byte=21 count=1",
                  bus.out_byte, bus.count);
      else pass_cnt++;
      drain();
   endtask

   task automatic test_back_to_back();
      do_reset(1'b0, 4'h0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         send_byte(8'(i), 1'b1);
         total_cnt++;
         if (bus.count > CW'(1))
            $display("FAIL stream_count: got %0d expected at most 1", bus.count);
         else pass_cnt++;
      end
      drain();
      total_cnt++;
      if (bus.overflow !== 1'b0)
         $display("FAIL stream_overflow: got %b expected 0", bus.overflow);
      else pass_cnt++;
   endtask

   task automatic test_parity();
      do_reset(1'b0, 4'h0);
      send_byte(8'h07, 1'b0);
      total_cnt++;
      if (bus.out_parity !== par(8'h07))
         $display("FAIL parity_07: got %b expected %b", bus.out_parity, par(8'h07));
      else pass_cnt++;
      bus.out_ready = 1'b1;
      cycle(1'b0, 4'h0);
      bus.out_ready = 1'b0;
      send_byte(8'h03, 1'b0);
      total_cnt++;
      if (bus.out_parity !== par(8'h03) || bus.out_byte !== 8'h03)
         $display("FAIL parity_03: got par=%b byte=%h expected par=%b byte=03",
                  bus.out_parity, bus.out_byte, par(8'h03));
      else pass_cnt++;
      drain();
   endtask

   task automatic test_random();
      logic [7:0] b;
      do_reset(1'b0, 4'h0);
      for (int i = 0; i < 12; i++) begin
         b = 8'($urandom_range(0, 255));
         bus.out_ready = 1'($urandom_range(0, 1));
         send_byte(b, 1'($urandom_range(0, 1)));
      end
      drain();
   endtask

   initial begin
      pass_cnt      = 0;
      total_cnt     = 0;
      rst           = 1'b1;
      bus.en        = 1'b0;
      bus.multiply  = 4'h0;
      bus.out_ready = 1'b0;
      clear_model();
      test_reset();
      test_single();
      test_overflow();
      test_full_pop();
      test_reset_partial();
      test_back_to_back();
      test_parity();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
